// File: rtl/xyolo_read_if.sv
// xyolo_read_if
//   Bundles the configuration, buffer read and operand/strobe signals of the
//   xyolo operand reader.
//   master : the reader. It takes in run, the loop configuration, bias and
//            the read data, and drives done, the read enables/addresses,
//            the operand streams and the ld_* strobes.
//   slave  : the environment, i.e. the controller, memories and write path.
interface xyolo_read_if #(
  parameter int DATAPATH_W = 32,
  parameter int N_MACS     = 1,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 10
);
  logic                         run;
  logic                         done;
  logic [CNT_W-1:0]             iter_a;
  logic [CNT_W-1:0]             per_a;
  logic [ADDR_W-1:0]            pix_start;
  logic [ADDR_W-1:0]            pix_incr;
  logic [ADDR_W-1:0]            pix_shift;
  logic [ADDR_W-1:0]            wgt_start;
  logic [2:0]                   mp_group;
  logic [DATAPATH_W-1:0]        bias_in;
  logic                         pix_en;
  logic [ADDR_W-1:0]            pix_addr;
  logic [N_MACS*DATAPATH_W-1:0] pix_rdata;
  logic                         wgt_en;
  logic [ADDR_W-1:0]            wgt_addr;
  logic [N_MACS*DATAPATH_W-1:0] wgt_rdata;
  logic [N_MACS*DATAPATH_W-1:0] flow_out_pixel;
  logic [N_MACS*DATAPATH_W-1:0] flow_out_weight;
  logic [DATAPATH_W-1:0]        flow_out_bias;
  logic                         ld_acc;
  logic                         ld_res;
  logic                         ld_mp;

  modport master (
    input  run, iter_a, per_a, pix_start, pix_incr, pix_shift, wgt_start,
           mp_group, bias_in, pix_rdata, wgt_rdata,
    output done, pix_en, pix_addr, wgt_en, wgt_addr, flow_out_pixel,
           flow_out_weight, flow_out_bias, ld_acc, ld_res, ld_mp
  );

  modport slave (
    output run, iter_a, per_a, pix_start, pix_incr, pix_shift, wgt_start,
           mp_group, bias_in, pix_rdata, wgt_rdata,
    input  done, pix_en, pix_addr, wgt_en, wgt_addr, flow_out_pixel,
           flow_out_weight, flow_out_bias, ld_acc, ld_res, ld_mp
  );
endinterface

// File: rtl/xyolo_read.sv
// xyolo_read
//   Operand reader and sequencer for the xyolo convolution datapath. It walks
//   iter_a outputs of per_a reads each over the pixel and weight buffers,
//   one read per cycle. It passes the returned words on as operand streams
//   and emits ld_acc / ld_res / ld_mp aligned to the datapath pipeline.
//   Ports: clk, rst (async, active-high), bus (xyolo_read_if.master).
module xyolo_read #(
  parameter int DATAPATH_W = 32,
  parameter int N_MACS     = 1,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 10,
  parameter int RES_DLY    = 7
) (
  input  logic         clk,
  input  logic         rst,
  xyolo_read_if.master bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      iter_r, per_r, k_r, j_r;
  logic [ADDR_W-1:0]     incr_r, shift_r, wstart_r, base_r;
  logic [ADDR_W-1:0]     pix_addr_r, wgt_addr_r;
  logic [2:0]            grp_r, m_r;
  logic [DATAPATH_W-1:0] bias_r;
  logic                  en_r, acc_r, done_r;
  // Stage i holds {last, mp} of an operand that appeared i cycles ago;
  // the final stage drives ld_res / ld_mp.
  logic [1:0]            dly_r [0:RES_DLY];

  logic                  k_last_s, j_last_s, m_last_s, zero_cfg_s, empty_s;
  logic [2:0]            grp_s;

  // Loop-end decodes, pool-group sanitising and delay-line occupancy.
  always_comb begin
    k_last_s   = (k_r == per_r - CNT_W'(1));
    j_last_s   = (j_r == iter_r - CNT_W'(1));
    m_last_s   = (m_r == grp_r - 3'd1);
    zero_cfg_s = (bus.iter_a == {CNT_W{1'b0}}) || (bus.per_a == {CNT_W{1'b0}});
    case (bus.mp_group)
      3'd1, 3'd2, 3'd3, 3'd4: grp_s = bus.mp_group;
      default:                grp_s = 3'd1;
    endcase
    empty_s = 1'b1;
    for (int i = 0; i <= RES_DLY; i++) begin
      empty_s = empty_s & ~dly_r[i][1];
    end
  end

  // Sequencer FSM, loop counters and incremental address generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      iter_r     <= {CNT_W{1'b0}};
      per_r      <= {CNT_W{1'b0}};
      k_r        <= {CNT_W{1'b0}};
      j_r        <= {CNT_W{1'b0}};
      incr_r     <= {ADDR_W{1'b0}};
      shift_r    <= {ADDR_W{1'b0}};
      wstart_r   <= {ADDR_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      pix_addr_r <= {ADDR_W{1'b0}};
      wgt_addr_r <= {ADDR_W{1'b0}};
      grp_r      <= 3'd1;
      m_r        <= 3'd0;
      bias_r     <= {DATAPATH_W{1'b0}};
      en_r       <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.run) begin
            iter_r   <= bus.iter_a;
            per_r    <= bus.per_a;
            incr_r   <= bus.pix_incr;
            shift_r  <= bus.pix_shift;
            wstart_r <= bus.wgt_start;
            grp_r    <= grp_s;
            bias_r   <= bus.bias_in;
            k_r      <= {CNT_W{1'b0}};
            j_r      <= {CNT_W{1'b0}};
            m_r      <= 3'd0;
            if (zero_cfg_s) begin
              // Nothing to read: report completion straight away.
              done_r <= 1'b1;
            end else begin
              done_r     <= 1'b0;
              state_r    <= ST_RUN;
              en_r       <= 1'b1;
              base_r     <= bus.pix_start;
              pix_addr_r <= bus.pix_start;
              wgt_addr_r <= bus.wgt_start;
            end
          end
        end
        ST_RUN: begin
          if (k_last_s) begin
            // Output finished: rewind the weights, step the pixel base.
            k_r        <= {CNT_W{1'b0}};
            m_r        <= m_last_s ? 3'd0 : m_r + 3'd1;
            base_r     <= base_r + shift_r;
            pix_addr_r <= base_r + shift_r;
            wgt_addr_r <= wstart_r;
            if (j_last_s) begin
              state_r <= ST_DRAIN;
              en_r    <= 1'b0;
            end else begin
              j_r <= j_r + CNT_W'(1);
            end
          end else begin
            k_r        <= k_r + CNT_W'(1);
            pix_addr_r <= pix_addr_r + incr_r;
            wgt_addr_r <= wgt_addr_r + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (empty_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          en_r    <= 1'b0;
        end
      endcase
    end
  end

  // Operand-aligned ld_acc and the result delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 1'b0;
      for (int i = 0; i <= RES_DLY; i++) begin
        dly_r[i] <= 2'b00;
      end
    end else begin
      acc_r    <= en_r && (k_r == {CNT_W{1'b0}});
      dly_r[0] <= {en_r && k_last_s, en_r && k_last_s && (m_r != 3'd0)};
      for (int i = 1; i <= RES_DLY; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  assign bus.done            = done_r;
  assign bus.pix_en          = en_r;
  assign bus.wgt_en          = en_r;
  assign bus.pix_addr        = pix_addr_r;
  assign bus.wgt_addr        = wgt_addr_r;
  assign bus.flow_out_pixel  = bus.pix_rdata;
  assign bus.flow_out_weight = bus.wgt_rdata;
  assign bus.flow_out_bias   = bias_r;
  assign bus.ld_acc          = acc_r;
  assign bus.ld_res          = dly_r[RES_DLY][1];
  assign bus.ld_mp           = dly_r[RES_DLY][0];
endmodule

// File: doc/xyolo_read.md
Name: xyolo_read

Overview:
- Operand reader and sequencer for the xyolo convolution datapath.
- Walks a configured accumulation window over the pixel and weight buffers. Issues one read per cycle to each buffer. Presents the returned words as the pixel, weight and bias operand streams.
- Emits ld_acc, ld_res and ld_mp time-aligned to the datapath pipeline, so the write side accumulates, pools and stores correctly.
- Sits between the on-chip feature/weight memories and the MAC/activation/maxpool write path.

Parameters:
- DATAPATH_W, 32: operand width per MAC lane.
- N_MACS, 1: MAC lanes; buffer read words are N_MACS*DATAPATH_W wide.
- ADDR_W, 10: buffer address width.
- CNT_W, 10: width of the loop counters and loop-count configuration.
- RES_DLY, 7: cycles from an operand appearing on flow_out_* to the datapath result being ready to latch (≥1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- run, input, 1: start pulse; sampled in IDLE only.
- done, output, 1: level; high after a run completes, cleared on the next accepted run.
- iter_a, input, CNT_W: number of outputs.
- per_a, input, CNT_W: accumulation length per output, in reads.
- pix_start, input, ADDR_W: first pixel address.
- pix_incr, input, ADDR_W: pixel stride within one accumulation.
- pix_shift, input, ADDR_W: pixel base advance between outputs.
- wgt_start, input, ADDR_W: first weight address; restarts for every output.
- mp_group, input, 3: outputs merged per maxpool group (1..4); 1 means no pooling.
- bias_in, input, DATAPATH_W: bias value, latched at run.
- pix_en, output, 1: pixel buffer read enable.
- pix_addr, output, ADDR_W: pixel buffer address.
- pix_rdata, input, N_MACS*DATAPATH_W: pixel data, valid 1 cycle after pix_en.
- wgt_en, output, 1: weight buffer read enable.
- wgt_addr, output, ADDR_W: weight buffer address.
- wgt_rdata, input, N_MACS*DATAPATH_W: weight data, valid 1 cycle after wgt_en.
- flow_out_pixel, output, N_MACS*DATAPATH_W: pixel operand (pix_rdata passed through).
- flow_out_weight, output, N_MACS*DATAPATH_W: weight operand (wgt_rdata passed through).
- flow_out_bias, output, DATAPATH_W: latched bias.
- ld_acc, output, 1: current operand starts a new accumulation.
- ld_res, output, 1: datapath result is ready; latch it.
- ld_mp, output, 1: latch through the max comparison (non-first output of a pool group).

Behaviour:
- Reset: FSM to IDLE; all counters, address registers and delay lines cleared. done, pix_en, wgt_en, ld_acc, ld_res, ld_mp = 0; pix_addr, wgt_addr = 0; flow_out_bias = 0.
- A reset mid-run aborts immediately: no further reads and no pending ld_res.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on run:
  - Latch all configuration and bias_in; clear done.
  - Counters k=0 (inner), j=0 (outer), mp index m=0.
- IDLE with run, and iter_a==0 or per_a==0: no reads. done=1 the next cycle; stay IDLE.
- run asserted while in RUN or DRAIN is ignored.
- RUN, every cycle:
  - pix_en = wgt_en = 1.
  - pix_addr = pix_start + j*pix_shift + k*pix_incr; wgt_addr = wgt_start + k.
  - Addresses are computed incrementally (adders only, no multipliers) and wrap modulo 2^ADDR_W.
- RUN counter update:
  - k increments each cycle; at k==per_a-1, k returns to 0 and j increments.
  - m increments per output and wraps at mp_group-1.
  - After the read with j==iter_a-1 and k==per_a-1, go to DRAIN.
- Operand alignment:
  - flow_out_pixel and flow_out_weight follow rdata combinationally.
  - ld_acc = 1 in the cycle after a read with k==0 was issued, i.e. aligned with that operand; 0 otherwise.
- Result strobes:
  - A 2-bit delay line of depth RES_DLY carries {last, mp}.
  - last marks the operand of k==per_a-1; mp = (m != 0) for that output.
  - ld_res pulses exactly RES_DLY cycles after the last operand of each output appears; ld_mp pulses in the same cycle when its mp bit is set.
  - One ld_res per output, iter_a in total.
- DRAIN:
  - pix_en = wgt_en = 0.
  - Wait until the delay line is empty, i.e. the final ld_res has been emitted.
  - Then go to IDLE and set done=1 the following cycle.
- Back-to-back runs: a run accepted the cycle done rises is legal; it restarts with fresh configuration.
- per_a==1: ld_acc is asserted on every operand cycle.
- mp_group values 0 or >4 are treated as 1.

Test Plan:
- Basic accumulation: iter_a=2, per_a=3, pix_start=0, pix_incr=1, pix_shift=3, wgt_start=16, mp_group=1.
  - pix_addr 0,1,2,3,4,5; wgt_addr 16,17,18,16,17,18.
  - ld_acc at operand cycles 1 and 4; ld_res exactly 7 cycles after operand cycles 3 and 6; ld_mp never.
  - done 1 cycle after DRAIN exits.
- Maxpool grouping: iter_a=4, per_a=1, mp_group=2.
  - ld_acc on every operand; 4 ld_res pulses; ld_mp only on the 2nd and 4th.
- Address wrap: ADDR_W=10, pix_start=1022, pix_incr=1, per_a=4, iter_a=1 -> pix_addr 1022,1023,0,1.
- Degenerate configuration: per_a=0 with run -> pix_en never asserted, done=1 next cycle, no ld_res.
- Abort and restart:
  - Assert rst during RUN after 5 reads -> all outputs 0 at once; no ld_res afterwards.
  - A subsequent run with iter_a=1, per_a=2 completes normally.
- Ignored run: pulse run during DRAIN -> no restart, exactly iter_a ld_res pulses, done asserted once.
